// File: rtl/vend_pkg.sv
// Shared types, coin values and seven-segment glyphs for the vending controller.
package vend_pkg;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    ONE  = 2'b01,
    TWO  = 2'b10,
    FIVE = 2'b11
  } coin_e;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    VEND,
    CHANGE
  } state_e;

  function automatic logic [6:0] coin_value(coin_e c);
    logic [6:0] v;
    v = 7'd0;
    unique case (c)
      NONE: v = 7'd0;
      ONE:  v = 7'd1;
      TWO:  v = 7'd2;
      FIVE: v = 7'd5;
      default: v = 7'd0;
    endcase
    return v;
  endfunction

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

endpackage

// File: rtl/vend_seg_dec.sv
// BCD digit to active-high seven-segment pattern (bit0 = a .. bit6 = g).
module vend_seg_dec
  import vend_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h00;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/vend_ctrl.sv
// Vending transaction controller: credit, vend pulse, greedy change, display.
// Optional idle refund timer in COLLECT is built when VEND_TIMEOUT_EN is defined.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE          = 15,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] coin_in,
  input  logic       cancel_in,
  input  logic       chg_ready,
  output logic       done_out,
  output logic       coin_rej,
  output logic       chg_valid,
  output logic [1:0] chg_coin,
  output logic [6:0] lsb7seg_out,
  output logic [6:0] msb7seg_out
);

  localparam logic [6:0] PRICE_V = 7'(PRICE);

  state_e     state_q, state_d;
  logic [6:0] credit_q, credit_d;
  logic [6:0] change_q, change_d;
  logic       done_q, done_d;
  logic       rej_q, rej_d;
  logic [6:0] lsb_q, msb_q;

  coin_e      coin;
  logic [6:0] cval;
  logic [6:0] sum;
  coin_e      give;
  logic       tmo;

  assign coin = coin_e'(coin_in);
  assign cval = coin_value(coin);
  assign sum  = credit_q + cval;

  always_comb begin
    give = ONE;
    unique case (1'b1)
      (change_q >= 7'd5):                     give = FIVE;
      (change_q >= 7'd2 && change_q < 7'd5):  give = TWO;
      default:                                give = ONE;
    endcase
  end

`ifdef VEND_TIMEOUT_EN
  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT_CYCLES - 1);

  logic [9:0] idle_q, idle_d;

  assign tmo = (state_q == COLLECT) && (coin == NONE) && (idle_q == TMO_LAST);

  // Counter only runs while waiting in COLLECT; any coin or state change clears it.
  always_comb begin
    idle_d = 10'd0;
    if (state_q == COLLECT && coin == NONE && !tmo)
      idle_d = idle_q + 10'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) idle_q <= 10'd0;
    else       idle_q <= idle_d;
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    change_d = change_q;
    done_d   = 1'b0;
    rej_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (coin != NONE) begin
          if (cval >= PRICE_V) begin
            change_d = cval - PRICE_V;
            credit_d = 7'd0;
            done_d   = 1'b1;
            state_d  = VEND;
          end else begin
            credit_d = cval;
            state_d  = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (sum >= PRICE_V) begin
          change_d = sum - PRICE_V;
          credit_d = 7'd0;
          done_d   = 1'b1;
          state_d  = VEND;
        end else if (cancel_in || tmo) begin
          change_d = sum;
          credit_d = 7'd0;
          state_d  = CHANGE;
        end else begin
          credit_d = sum;
        end
      end
      VEND: begin
        rej_d   = (coin != NONE);
        state_d = (change_q != 7'd0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        rej_d = (coin != NONE);
        if (chg_ready) begin
          change_d = change_q - coin_value(give);
          if (change_d == 7'd0) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic [6:0] disp_val;
  logic [6:0] tens, ones;
  logic [6:0] lsb_d, msb_d;

  assign disp_val = (state_q == VEND || state_q == CHANGE) ? change_q : credit_q;
  assign tens     = disp_val / 7'd10;
  assign ones     = disp_val % 7'd10;

  vend_seg_dec u_seg_lsb (.bcd(ones[3:0]), .seg(lsb_d));
  vend_seg_dec u_seg_msb (.bcd(tens[3:0]), .seg(msb_d));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      credit_q <= 7'd0;
      change_q <= 7'd0;
      done_q   <= 1'b0;
      rej_q    <= 1'b0;
      lsb_q    <= SEG_0;
      msb_q    <= SEG_0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      change_q <= change_d;
      done_q   <= done_d;
      rej_q    <= rej_d;
      lsb_q    <= lsb_d;
      msb_q    <= msb_d;
    end
  end

  assign done_out    = done_q;
  assign coin_rej    = rej_q;
  assign chg_valid   = (state_q == CHANGE);
  assign chg_coin    = (state_q == CHANGE) ? give : NONE;
  assign lsb7seg_out = lsb_q;
  assign msb7seg_out = msb_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: vector table, corner sequences, random vs model.
module tb_vend_ctrl;

  localparam int PRICE = 15;
`ifdef VEND_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1000;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] coin_in;
  logic       cancel_in;
  logic       chg_ready;
  logic       done_out;
  logic       coin_rej;
  logic       chg_valid;
  logic [1:0] chg_coin;
  logic [6:0] lsb7seg_out;
  logic [6:0] msb7seg_out;

  vend_ctrl #(.PRICE(PRICE), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .coin_in(coin_in),
    .cancel_in(cancel_in), .chg_ready(chg_ready),
    .done_out(done_out), .coin_rej(coin_rej),
    .chg_valid(chg_valid), .chg_coin(chg_coin),
    .lsb7seg_out(lsb7seg_out), .msb7seg_out(msb7seg_out)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  logic [6:0] seg_tab [10];
  initial begin
    seg_tab[0] = 7'h3F; seg_tab[1] = 7'h06; seg_tab[2] = 7'h5B;
    seg_tab[3] = 7'h4F; seg_tab[4] = 7'h66; seg_tab[5] = 7'h6D;
    seg_tab[6] = 7'h7D; seg_tab[7] = 7'h07; seg_tab[8] = 7'h7F;
    seg_tab[9] = 7'h6F;
  end

  task automatic chk(input string name, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step(input logic [1:0] c, input logic can, input logic rdy);
    coin_in = c; cancel_in = can; chg_ready = rdy;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic d, input logic r,
                         input logic v, input logic [1:0] cc,
                         input logic [6:0] l, input logic [6:0] m);
    chk({tag, ".done"}, {6'd0, done_out}, {6'd0, d});
    chk({tag, ".rej"}, {6'd0, coin_rej}, {6'd0, r});
    chk({tag, ".valid"}, {6'd0, chg_valid}, {6'd0, v});
    chk({tag, ".coin"}, {5'd0, chg_coin}, {5'd0, cc});
    chk({tag, ".lsb"}, lsb7seg_out, l);
    chk({tag, ".msb"}, msb7seg_out, m);
  endtask

  typedef struct {
    logic [1:0] coin;
    logic       can;
    logic       rdy;
    logic       done;
    logic       valid;
    logic [1:0] cc;
    logic [6:0] lsb;
    logic [6:0] msb;
  } vec_t;

  vec_t vecs [17];

  // Reference model: transaction-level view of credit and pending change.
  int  m_credit, m_change;
  bit  m_vending, m_refund;
  logic       e_done, e_rej, e_valid;
  logic [1:0] e_cc;
  logic [6:0] e_lsb, e_msb;

  function automatic int val_of(input logic [1:0] c);
    int r;
    r = (c == 2'b01) ? 1 : (c == 2'b10) ? 2 : (c == 2'b11) ? 5 : 0;
    return r;
  endfunction

  function automatic int best_coin(input int amt);
    int r;
    r = (amt >= 5) ? 5 : (amt >= 2) ? 2 : 1;
    return r;
  endfunction

  function automatic logic [1:0] code_of(input int v);
    logic [1:0] r;
    r = (v == 5) ? 2'b11 : (v == 2) ? 2'b10 : 2'b01;
    return r;
  endfunction

  task automatic model_reset();
    m_credit = 0; m_change = 0; m_vending = 0; m_refund = 0;
  endtask

  task automatic model_edge(input logic [1:0] c, input logic can,
                            input logic rdy, input logic rst);
    int shown, sum;
    shown = (m_vending || m_refund) ? m_change : m_credit;
    e_done = 0;
    e_rej  = 0;
    if (rst) begin
      model_reset();
      shown = 0;
    end else if (m_vending) begin
      e_rej = (c != 2'b00);
      m_vending = 0;
      m_refund = (m_change > 0);
    end else if (m_refund) begin
      e_rej = (c != 2'b00);
      if (rdy) begin
        m_change -= best_coin(m_change);
        if (m_change == 0) m_refund = 0;
      end
    end else begin
      sum = m_credit + val_of(c);
      if (sum >= PRICE) begin
        m_change = sum - PRICE; m_credit = 0; e_done = 1; m_vending = 1;
      end else if (can && m_credit > 0) begin
        m_change = sum; m_credit = 0; m_refund = 1;
      end else begin
        m_credit = sum;
      end
    end
    e_valid = m_refund;
    e_cc    = m_refund ? code_of(best_coin(m_change)) : 2'b00;
    e_lsb   = seg_tab[shown % 10];
    e_msb   = seg_tab[shown / 10];
  endtask

  initial begin
    logic [6:0] z, o, t;
    logic [1:0] rc;
    logic rcan, rrdy, rrst;
    z = 7'h3F; o = 7'h06; t = 7'h5B;

    //        coin  can rdy done val cc     lsb    msb
    vecs[0]  = '{2'b10, 0, 0, 0, 0, 2'b00, z,     z};
    vecs[1]  = '{2'b10, 0, 0, 0, 0, 2'b00, t,     z};
    vecs[2]  = '{2'b11, 0, 0, 0, 0, 2'b00, 7'h66, z};
    vecs[3]  = '{2'b01, 0, 0, 0, 0, 2'b00, 7'h6F, z};
    vecs[4]  = '{2'b00, 0, 0, 0, 0, 2'b00, z,     o};
    vecs[5]  = '{2'b11, 0, 0, 1, 0, 2'b00, z,     o};
    vecs[6]  = '{2'b00, 0, 0, 0, 0, 2'b00, z,     z};
    vecs[7]  = '{2'b00, 1, 0, 0, 0, 2'b00, z,     z};
    vecs[8]  = '{2'b11, 0, 0, 0, 0, 2'b00, z,     z};
    vecs[9]  = '{2'b11, 0, 0, 0, 0, 2'b00, 7'h6D, z};
    vecs[10] = '{2'b01, 0, 0, 0, 0, 2'b00, z,     o};
    vecs[11] = '{2'b10, 0, 0, 0, 0, 2'b00, o,     o};
    vecs[12] = '{2'b11, 0, 1, 1, 0, 2'b00, 7'h4F, o};
    vecs[13] = '{2'b00, 0, 1, 0, 1, 2'b10, 7'h4F, z};
    vecs[14] = '{2'b00, 0, 1, 0, 1, 2'b01, 7'h4F, z};
    vecs[15] = '{2'b00, 0, 1, 0, 0, 2'b00, o,     z};
    vecs[16] = '{2'b00, 0, 1, 0, 0, 2'b00, z,     z};

    reset = 1; coin_in = 0; cancel_in = 0; chg_ready = 0;
    repeat (2) @(posedge clock);
    #1;
    chk_all("reset", 0, 0, 0, 2'b00, z, z);
    reset = 0;

    foreach (vecs[i]) begin
      step(vecs[i].coin, vecs[i].can, vecs[i].rdy);
      chk_all($sformatf("vec%0d", i), vecs[i].done, 1'b0, vecs[i].valid,
              vecs[i].cc, vecs[i].lsb, vecs[i].msb);
    end

    // Credit 7 then cancel with the change mechanism stalled.
    step(2'b11, 0, 0);
    step(2'b10, 0, 0);
    step(2'b00, 1, 0);
    chk_all("cancel", 0, 0, 1, 2'b11, 7'h07, z);
    for (int i = 0; i < 5; i++) begin
      step(2'b00, 0, 0);
      chk({"stall.valid"}, {6'd0, chg_valid}, 7'd1);
      chk({"stall.coin"}, {5'd0, chg_coin}, 7'd3);
    end
    step(2'b00, 0, 1);
    chk("rel1.coin", {5'd0, chg_coin}, 7'd2);
    step(2'b01, 0, 0);
    chk("inchg.rej", {6'd0, coin_rej}, 7'd1);
    chk("inchg.coin", {5'd0, chg_coin}, 7'd2);
    chk("inchg.valid", {6'd0, chg_valid}, 7'd1);
    step(2'b00, 0, 1);
    chk_all("rel2", 0, 0, 0, 2'b00, t, z);

    // Reset in the middle of a refund.
    step(2'b11, 0, 0);
    step(2'b10, 0, 0);
    step(2'b00, 1, 0);
    chk("prerst.valid", {6'd0, chg_valid}, 7'd1);
    reset = 1;
    step(2'b00, 0, 0);
    chk_all("midrst", 0, 0, 0, 2'b00, z, z);
    reset = 0;

`ifdef VEND_TIMEOUT_EN
    step(2'b10, 0, 0);
    for (int i = 0; i < 7; i++) begin
      step(2'b00, 0, 0);
      chk("tmo.wait", {5'd0, done_out, chg_valid}, 7'd0);
    end
    step(2'b00, 0, 0);
    chk_all("tmo.fire", 0, 0, 1, 2'b10, t, z);
    step(2'b00, 0, 1);
    chk("tmo.done", {6'd0, chg_valid}, 7'd0);
`else
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      rc   = 2'($urandom_range(0, 3));
      rcan = ($urandom_range(0, 7) == 0);
      rrdy = ($urandom_range(0, 1) == 1);
      rrst = ($urandom_range(0, 199) == 0);
      model_edge(rc, rcan, rrdy, rrst);
      reset = rrst;
      step(rc, rcan, rrdy);
      chk_all($sformatf("rnd%0d", i), e_done, e_rej, e_valid, e_cc, e_lsb, e_msb);
    end
    reset = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
